// File: rtl/det_sweep_pkg.sv
// Shared widths, FSM state encoding and constants for the detector sweep controller.
package det_sweep_pkg;

    localparam int VEC_W = 9;
    localparam int CNT_W = VEC_W + 1;
    localparam logic [VEC_W-1:0] ALL_ONES = '1;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SETTLE,
        SAMPLE,
        DONE
    } sweep_state_t;

endpackage

// File: rtl/det_sweep_addr_gen.sv
// Vector generator for the sweep: latches the range end, walks the current vector
// upward with wrap-around and flags the last vector of the range.
module det_sweep_addr_gen
    import det_sweep_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             advance,
    input  logic [VEC_W-1:0] cfgLo,
    input  logic [VEC_W-1:0] cfgHi,
    output logic [VEC_W-1:0] cur,
    output logic             isLast
);

    logic [VEC_W-1:0] hiQ;

    // Only the end bound needs keeping; the start bound seeds the current vector.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur <= '0;
            hiQ <= '0;
        end else if (load) begin
            cur <= cfgLo;
            hiQ <= cfgHi;
        end else if (advance) begin
            cur <= cur + VEC_W'(1);
        end
    end

    assign isLast = (cur == hiQ);

endmodule

// File: rtl/det_sweep_ctrl.sv
// Sweep sequencer driving two all-ones detectors and comparing their responses.
// Optional golden-model error counters are enabled by defining DET_SWEEP_GOLDEN_EN.
module det_sweep_ctrl
    import det_sweep_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [VEC_W-1:0] cfg_lo,
    input  logic [VEC_W-1:0] cfg_hi,
    input  logic             det1_bit,
    input  logic             det2_bit,
    output logic [VEC_W-1:0] M,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] hit_cnt,
    output logic [CNT_W-1:0] mismatch_cnt,
    output logic             first_mm_valid,
`ifdef DET_SWEEP_GOLDEN_EN
    output logic [CNT_W-1:0] err1_cnt,
    output logic [CNT_W-1:0] err2_cnt,
`endif
    output logic [VEC_W-1:0] first_mm_vec
);

    localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES - 1);

    sweep_state_t     state;
    logic [3:0]       settleCnt;
    logic [VEC_W-1:0] curVec;
    logic             isLast;
    logic             accept;
    logic             advance;
    logic             bitsDiffer;

    // Abort takes priority over a start arriving in the same cycle.
    assign accept     = start && !abort && (state == IDLE || state == DONE);
    assign advance    = (state == SAMPLE) && !abort && !isLast;
    assign bitsDiffer = (det1_bit != det2_bit);

    det_sweep_addr_gen u_addr_gen (
        .clk    (clk),
        .rst    (rst),
        .load   (accept),
        .advance(advance),
        .cfgLo  (cfg_lo),
        .cfgHi  (cfg_hi),
        .cur    (curVec),
        .isLast (isLast)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            settleCnt      <= '0;
            M              <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            hit_cnt        <= '0;
            mismatch_cnt   <= '0;
            first_mm_valid <= 1'b0;
            first_mm_vec   <= '0;
`ifdef DET_SWEEP_GOLDEN_EN
            err1_cnt       <= '0;
            err2_cnt       <= '0;
`endif
        end else if (abort && state != IDLE) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (accept) begin
                        state          <= LOAD;
                        busy           <= 1'b1;
                        done           <= 1'b0;
                        hit_cnt        <= '0;
                        mismatch_cnt   <= '0;
                        first_mm_valid <= 1'b0;
                        first_mm_vec   <= '0;
`ifdef DET_SWEEP_GOLDEN_EN
                        err1_cnt       <= '0;
                        err2_cnt       <= '0;
`endif
                    end
                end
                LOAD: begin
                    M         <= curVec;
                    settleCnt <= SETTLE_INIT;
                    state     <= SETTLE;
                end
                SETTLE: begin
                    if (settleCnt == 4'd0) begin
                        state <= SAMPLE;
                    end else begin
                        settleCnt <= settleCnt - 4'd1;
                    end
                end
                SAMPLE: begin
                    hit_cnt      <= hit_cnt + CNT_W'(det1_bit & det2_bit);
                    mismatch_cnt <= mismatch_cnt + CNT_W'(bitsDiffer);
                    if (bitsDiffer && !first_mm_valid) begin
                        first_mm_valid <= 1'b1;
                        first_mm_vec   <= M;
                    end
`ifdef DET_SWEEP_GOLDEN_EN
                    err1_cnt <= err1_cnt + CNT_W'(det1_bit != (M == ALL_ONES));
                    err2_cnt <= err2_cnt + CNT_W'(det2_bit != (M == ALL_ONES));
`endif
                    if (isLast) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        state <= LOAD;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_det_sweep_ctrl.sv
// Self-checking bench for det_sweep_ctrl: detector models, vector-order scoreboard,
// sweep result checks, abort, restart and asynchronous reset scenarios.
module tb_det_sweep_ctrl;
    import det_sweep_pkg::*;

    localparam int SETTLE  = 1;
    localparam int PER_VEC = SETTLE + 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             abort;
    logic [VEC_W-1:0] cfg_lo;
    logic [VEC_W-1:0] cfg_hi;
    logic             det1_bit;
    logic             det2_bit;
    logic             det2Faulty;
    logic [VEC_W-1:0] M;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] hit_cnt;
    logic [CNT_W-1:0] mismatch_cnt;
    logic             first_mm_valid;
    logic [VEC_W-1:0] first_mm_vec;
`ifdef DET_SWEEP_GOLDEN_EN
    logic [CNT_W-1:0] err1_cnt;
    logic [CNT_W-1:0] err2_cnt;
    int               expErr2Last;
`endif

    int               total = 0;
    int               bad = 0;
    logic [VEC_W-1:0] exp_q[$];
    logic [VEC_W-1:0] monVec;

    det_sweep_ctrl #(.SETTLE_CYCLES(SETTLE)) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .abort         (abort),
        .cfg_lo        (cfg_lo),
        .cfg_hi        (cfg_hi),
        .det1_bit      (det1_bit),
        .det2_bit      (det2_bit),
        .M             (M),
        .busy          (busy),
        .done          (done),
        .hit_cnt       (hit_cnt),
        .mismatch_cnt  (mismatch_cnt),
        .first_mm_valid(first_mm_valid),
`ifdef DET_SWEEP_GOLDEN_EN
        .err1_cnt      (err1_cnt),
        .err2_cnt      (err2_cnt),
`endif
        .first_mm_vec  (first_mm_vec)
    );

    always #5 clk = ~clk;

    // Detector models: detector1 is a correct all-ones detector, detector2 can be stuck at 1.
    assign det1_bit = &M;
    assign det2_bit = det2Faulty | (&M);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Every sampled vector must be the next one the bench expects, in order.
    always @(negedge clk) begin
        if (!rst && dut.state == SAMPLE) begin
            if (exp_q.size() == 0) begin
                check("vec_extra", 32'(M), 32'hFFFF_FFFF);
            end else begin
                monVec = exp_q.pop_front();
                check("vec_order", 32'(M), 32'(monVec));
            end
        end
    end

    task automatic pushRange(input logic [VEC_W-1:0] lo, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(lo + VEC_W'(i));
    endtask

    task automatic pulseStart(input logic [VEC_W-1:0] lo, input logic [VEC_W-1:0] hi);
        @(negedge clk);
        cfg_lo = lo;
        cfg_hi = hi;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
        cfg_lo = VEC_W'($urandom_range(0, 511));
        cfg_hi = VEC_W'($urandom_range(0, 511));
    endtask

    task automatic runSweep(input logic [VEC_W-1:0] lo, input logic [VEC_W-1:0] hi,
                            input logic faulty, input string tag);
        int n, cyc, expHit, expMm, expFv, expFvec, expE2;
        logic [VEC_W-1:0] v;
        logic a, d2;
        n = ((int'(hi) - int'(lo) + 512) % 512) + 1;
        expHit = 0; expMm = 0; expFv = 0; expFvec = 0; expE2 = 0;
        for (int i = 0; i < n; i++) begin
            v  = lo + VEC_W'(i);
            a  = &v;
            d2 = faulty | a;
            expHit += int'(a & d2);
            if (a != d2) begin
                expMm++;
                expE2++;
                if (expFv == 0) begin
                    expFv   = 1;
                    expFvec = int'(v);
                end
            end
        end
        pushRange(lo, n);
        det2Faulty = faulty;
        pulseStart(lo, hi);
        check({tag, "_busy_start"}, busy, 1);
        check({tag, "_done_clr"}, done, 0);
        cyc = 0;
        while (!done && cyc < n * PER_VEC + 50) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check({tag, "_cycles"}, cyc, n * PER_VEC);
        check({tag, "_done"}, done, 1);
        check({tag, "_busy_end"}, busy, 0);
        check({tag, "_hit"}, hit_cnt, expHit);
        check({tag, "_mm"}, mismatch_cnt, expMm);
        check({tag, "_fmv"}, first_mm_valid, expFv);
        check({tag, "_fmvec"}, first_mm_vec, expFvec);
        check({tag, "_lastM"}, M, hi);
        check({tag, "_q_left"}, exp_q.size(), 0);
`ifdef DET_SWEEP_GOLDEN_EN
        check({tag, "_err1"}, err1_cnt, 0);
        check({tag, "_err2"}, err2_cnt, expE2);
        expErr2Last = expE2;
`endif
        exp_q.delete();
    endtask

    initial begin
        logic [VEC_W-1:0] rlo;
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        cfg_lo = '0; cfg_hi = '0; det2Faulty = 1'b0;
        #12;
        check("rst_M", M, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_hit", hit_cnt, 0);
        check("rst_mm", mismatch_cnt, 0);
        check("rst_fmv", first_mm_valid, 0);
        check("rst_fmvec", first_mm_vec, 0);
        @(negedge clk);
        rst = 1'b0;

        runSweep(9'd0, 9'd511, 1'b0, "full");
        runSweep(9'd511, 9'd511, 1'b0, "single_511");
        runSweep(9'd0, 9'd0, 1'b0, "single_0");
        runSweep(9'd500, 9'd3, 1'b0, "wrap");
        runSweep(9'd508, 9'd511, 1'b1, "faulty");
        runSweep(9'd100, 9'd99, 1'b0, "all_wrap");
        for (int k = 0; k < 3; k++) begin
            rlo = VEC_W'($urandom_range(0, 511));
            runSweep(rlo, rlo + VEC_W'($urandom_range(0, 20)), 1'($urandom_range(0, 1)), "rand");
        end

        // Abort at clock 20 of a faulty full sweep: vectors 0..5 sampled, M holds 6.
        pushRange(9'd0, 512);
        det2Faulty = 1'b1;
        pulseStart(9'd0, 9'd511);
        repeat (19) @(posedge clk);
        @(negedge clk);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_mm_hold", mismatch_cnt, 6);
        check("abort_hit_hold", hit_cnt, 0);
        check("abort_fmv_hold", first_mm_valid, 1);
        check("abort_M_hold", M, 6);
        check("abort_q_left", exp_q.size(), 506);
        exp_q.delete();
        @(posedge clk);
        #1;
        check("abort_idle_busy", busy, 0);
        check("abort_idle_done", done, 0);
        runSweep(9'd0, 9'd1, 1'b0, "restart");

        // Start while busy is ignored; async reset lands mid-SETTLE of vector 7.
        pushRange(9'd0, 512);
        det2Faulty = 1'b1;
        pulseStart(9'd0, 9'd511);
        repeat (9) @(posedge clk);
        @(negedge clk);
        cfg_lo = 9'd100;
        cfg_hi = 9'd100;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("busy_start_ignored", busy, 1);
        check("busy_start_no_clear", mismatch_cnt, 3);
        repeat (12) @(posedge clk);
        #1;
        check("busy_start_continue", mismatch_cnt, 7);
        check("busy_start_M", M, 7);
        #2;
        rst = 1'b1;
        #1;
        check("arst_M", M, 0);
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        check("arst_hit", hit_cnt, 0);
        check("arst_mm", mismatch_cnt, 0);
        check("arst_fmv", first_mm_valid, 0);
        check("arst_fmvec", first_mm_vec, 0);
`ifdef DET_SWEEP_GOLDEN_EN
        check("arst_err2", err2_cnt, 0);
`endif
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_done", done, 0);
        runSweep(9'd508, 9'd511, 1'b1, "post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
